// File: rtl/fmt1_pkg.sv
// Shared constants for the MSP430 format-I sequencer: opcodes, ALU function
// selects, addressing modes, address-source codes and the sequencer states.
package fmt1_pkg;

  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_SUBC = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_DADD = 4'hA;
  localparam logic [3:0] OP_BIT  = 4'hB;
  localparam logic [3:0] OP_BIC  = 4'hC;
  localparam logic [3:0] OP_BIS  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_AND  = 4'hF;

  // FS[3] inverts source, FS[2] selects arithmetic, FS[1:0] picks the logic op
  localparam logic [3:0] FS_AND  = 4'b0000;
  localparam logic [3:0] FS_OR   = 4'b0001;
  localparam logic [3:0] FS_XOR  = 4'b0010;
  localparam logic [3:0] FS_PASS = 4'b0011;
  localparam logic [3:0] FS_ADD  = 4'b0100;
  localparam logic [3:0] FS_ADDC = 4'b0101;
  localparam logic [3:0] FS_DADD = 4'b0110;
  localparam logic [3:0] FS_BIC  = 4'b1000;
  localparam logic [3:0] FS_SUB  = 4'b1100;
  localparam logic [3:0] FS_SUBC = 4'b1101;

  localparam logic [1:0] ADDR_PC    = 2'b00;
  localparam logic [1:0] ADDR_SRC_X = 2'b01;
  localparam logic [1:0] ADDR_SRC   = 2'b10;
  localparam logic [1:0] ADDR_DST_X = 2'b11;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IDX = 2'b01;
  localparam logic [1:0] AS_IND = 2'b10;
  localparam logic [1:0] AS_INC = 2'b11;
  localparam logic       AD_IDX = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_SRC_EXT, S_SRC_MEM, S_DST_EXT, S_DST_MEM, S_EXEC, S_WB_MEM
  } state_t;

  // R3 always, and R2 in the indirect modes, source constants instead of memory
  function automatic logic is_cg(input logic [3:0] rsrc, input logic [1:0] as_m);
    return (rsrc == 4'd3) || ((rsrc == 4'd2) && as_m[1]);
  endfunction

endpackage

// File: rtl/fmt1_op_decode.sv
// Format-I opcode decode: ALU function select plus writeback / SR-update flags.
module fmt1_op_decode
  import fmt1_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [3:0] fs,
  output logic       writeback,
  output logic       sr_update,
  output logic       is_fmt1
);

  always_comb begin
    fs        = FS_AND;
    writeback = 1'b1;
    sr_update = 1'b1;
    is_fmt1   = 1'b1;
    case (opcode)
      OP_MOV:  begin fs = FS_PASS; sr_update = 1'b0; end
      OP_ADD:  fs = FS_ADD;
      OP_ADDC: fs = FS_ADDC;
      OP_SUBC: fs = FS_SUBC;
      OP_SUB:  fs = FS_SUB;
      OP_CMP:  begin fs = FS_SUB; writeback = 1'b0; end
      OP_DADD: fs = FS_DADD;
      OP_BIT:  begin fs = FS_AND; writeback = 1'b0; end
      OP_BIC:  begin fs = FS_BIC; sr_update = 1'b0; end
      OP_BIS:  begin fs = FS_OR;  sr_update = 1'b0; end
      OP_XOR:  fs = FS_XOR;
      OP_AND:  fs = FS_AND;
      default: begin writeback = 1'b0; sr_update = 1'b0; is_fmt1 = 1'b0; end
    endcase
  end

endmodule

// File: rtl/fmt1_sequencer.sv
// Multi-cycle control sequencer for MSP430 format-I instructions: operand
// fetch, one execute cycle and register/memory writeback.
module fmt1_sequencer
  import fmt1_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid,
  input  logic [15:0] ins,
  output logic        ins_ready,
  output logic        ext_req,
  input  logic        ext_ack,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ack,
  output logic [1:0]  addr_sel,
  output logic        cg_en,
  output logic        src_inc,
  output logic [3:0]  fs,
  output logic        bw,
  output logic        alu_en,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        sr_we,
  output logic        fmt_other,
  output logic        done
);

  state_t      state, state_nxt, dst_nxt;
  logic [15:0] ins_q, cur;
  logic        accept, cg;
  logic [3:0]  opc, rsrc, rdst;
  logic        ad, bw_b;
  logic [1:0]  as_m;
  logic [3:0]  dec_fs;
  logic        dec_wb, dec_sr, dec_fmt1;

  // Decode the live word in the accept cycle so fs/bw/cg_en are valid there too
  assign accept = rst_n && (state == S_IDLE) && ins_valid;
  assign cur    = accept ? ins : ins_q;
  assign {opc, rsrc, ad, bw_b, as_m, rdst} = cur;
  assign cg      = is_cg(rsrc, as_m);
  assign dst_nxt = (ad == AD_IDX) ? S_DST_EXT : S_EXEC;

  fmt1_op_decode u_dec (
    .opcode    (opc),
    .fs        (dec_fs),
    .writeback (dec_wb),
    .sr_update (dec_sr),
    .is_fmt1   (dec_fmt1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ins_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) ins_q <= ins;
    end
  end

  always_comb begin
    state_nxt = state;
    ins_ready = 1'b0;
    ext_req   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = ADDR_PC;
    cg_en     = 1'b0;
    src_inc   = 1'b0;
    fs        = 4'b0000;
    bw        = 1'b0;
    alu_en    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = 4'd0;
    sr_we     = 1'b0;
    fmt_other = 1'b0;
    done      = 1'b0;
    // Everything stays quiet while reset is held
    if (rst_n) begin
      fs    = dec_fs;
      bw    = (SIZE > 8) ? bw_b : 1'b0;
      cg_en = dec_fmt1 && cg && (state != S_WB_MEM) && ((state != S_IDLE) || accept);
      case (state)
        S_IDLE: begin
          ins_ready = 1'b1;
          if (ins_valid) begin
            if (!dec_fmt1) fmt_other = 1'b1;
            else if (cg)   state_nxt = dst_nxt;
            else begin
              case (as_m)
                AS_REG:  state_nxt = dst_nxt;
                AS_IDX:  state_nxt = S_SRC_EXT;
                AS_IND:  state_nxt = S_SRC_MEM;
                default: state_nxt = (rsrc == 4'd0) ? S_SRC_EXT : S_SRC_MEM;
              endcase
            end
          end
        end
        S_SRC_EXT: begin
          ext_req = 1'b1;
          // Immediate has its operand in the extension word; indexed still needs a read
          if (ext_ack) state_nxt = (as_m == AS_INC) ? dst_nxt : S_SRC_MEM;
        end
        S_SRC_MEM: begin
          mem_rd   = 1'b1;
          addr_sel = (as_m == AS_IDX) ? ADDR_SRC_X : ADDR_SRC;
          if (mem_ack) begin
            src_inc   = (as_m == AS_INC);
            state_nxt = dst_nxt;
          end
        end
        S_DST_EXT: begin
          ext_req = 1'b1;
          if (ext_ack) state_nxt = S_DST_MEM;
        end
        S_DST_MEM: begin
          mem_rd   = 1'b1;
          addr_sel = ADDR_DST_X;
          if (mem_ack) state_nxt = S_EXEC;
        end
        S_EXEC: begin
          alu_en = 1'b1;
          sr_we  = dec_sr;
          if (dec_wb && (ad == AD_IDX)) state_nxt = S_WB_MEM;
          else begin
            rf_we     = dec_wb;
            rf_waddr  = dec_wb ? rdst : 4'd0;
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_WB_MEM: begin
          mem_wr   = 1'b1;
          addr_sel = ADDR_DST_X;
          if (mem_ack) begin
            done      = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fmt1_sequencer.sv
// Bench for fmt1_sequencer: a phase-list model of each instruction, checked
// every cycle, plus literal expectations for the canonical instructions.
module tb_fmt1_sequencer;

  logic        clk = 1'b0, rst_n = 1'b0, ins_valid = 1'b0, ext_ack = 1'b0, mem_ack = 1'b0;
  logic [15:0] ins = 16'h0;
  logic        ins_ready, ext_req, mem_rd, mem_wr, cg_en, src_inc, bw, alu_en, rf_we, sr_we, fmt_other, done;
  logic [1:0]  addr_sel;
  logic [3:0]  fs, rf_waddr;

  always #5 clk = ~clk;

  fmt1_sequencer #(.SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .ins(ins), .ins_ready(ins_ready),
    .ext_req(ext_req), .ext_ack(ext_ack), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ack(mem_ack),
    .addr_sel(addr_sel), .cg_en(cg_en), .src_inc(src_inc), .fs(fs), .bw(bw), .alu_en(alu_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .sr_we(sr_we), .fmt_other(fmt_other), .done(done)
  );

  typedef enum int {P_SRC_EXT, P_SRC_IDX, P_SRC_IND, P_SRC_INC, P_DST_EXT, P_DST_MEM, P_EXEC, P_WB} phase_t;
  phase_t      ph[$];
  logic [15:0] m_ins = 16'h0;
  int          n_vec = 0, n_bad = 0;

  function automatic logic [3:0] fs_of(input logic [3:0] op);
    case (op)
      4'h4: return 4'b0011;  4'h5: return 4'b0100;  4'h6: return 4'b0101;
      4'h7: return 4'b1101;  4'h8: return 4'b1100;  4'h9: return 4'b1100;
      4'hA: return 4'b0110;  4'hB: return 4'b0000;  4'hC: return 4'b1000;
      4'hD: return 4'b0001;  4'hE: return 4'b0010;  default: return 4'b0000;
    endcase
  endfunction

  function automatic logic wb_of(input logic [3:0] op);
    return (op >= 4) && (op != 4'h9) && (op != 4'hB);
  endfunction

  function automatic logic sr_of(input logic [3:0] op);
    return (op >= 4) && (op != 4'h4) && (op != 4'hC) && (op != 4'hD);
  endfunction

  function automatic logic cg_of(input logic [15:0] w);
    return (w[11:8] == 4'd3) || ((w[11:8] == 4'd2) && (w[5:4] >= 2'd2));
  endfunction

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Expand an accepted format-I word into the phases it must walk through
  task automatic build(input logic [15:0] w);
    logic ad;
    ad = w[7];
    if (!cg_of(w)) begin
      case (w[5:4])
        2'd1: begin ph.push_back(P_SRC_EXT); ph.push_back(P_SRC_IDX); end
        2'd2: ph.push_back(P_SRC_IND);
        2'd3: ph.push_back((w[11:8] == 4'd0) ? P_SRC_EXT : P_SRC_INC);
        default: ;
      endcase
    end
    if (ad) begin ph.push_back(P_DST_EXT); ph.push_back(P_DST_MEM); end
    ph.push_back(P_EXEC);
    if (ad && wb_of(w[15:12])) ph.push_back(P_WB);
  endtask

  task automatic advance();
    if (!rst_n) begin
      ph.delete();
      m_ins = 16'h0;
    end else if (ph.size() == 0) begin
      if (ins_valid) begin
        m_ins = ins;
        if (ins[15:12] >= 4) build(ins);
      end
    end else begin
      case (ph[0])
        P_SRC_EXT, P_DST_EXT: if (ext_ack) void'(ph.pop_front());
        P_EXEC:               void'(ph.pop_front());
        default:              if (mem_ack) void'(ph.pop_front());
      endcase
    end
  endtask

  task automatic check_cycle();
    logic e_rdy, e_ext, e_rd, e_wr, e_cg, e_inc, e_bw, e_alu, e_we, e_sr, e_oth, e_done;
    logic [1:0]  e_addr;
    logic [3:0]  e_fs, e_wa, op;
    logic [15:0] w;
    {e_rdy, e_ext, e_rd, e_wr, e_cg, e_inc, e_bw, e_alu, e_we, e_sr, e_oth, e_done} = '0;
    e_addr = 2'd0; e_fs = 4'd0; e_wa = 4'd0;
    if (rst_n) begin
      w    = (ph.size() == 0 && ins_valid) ? ins : m_ins;
      op   = w[15:12];
      e_fs = fs_of(op);
      e_bw = w[6];
      if (ph.size() == 0) begin
        e_rdy = 1'b1;
        if (ins_valid) begin
          e_oth = (op < 4);
          e_cg  = (op >= 4) && cg_of(w);
        end
      end else begin
        e_cg = cg_of(w) && (ph[0] != P_WB);
        case (ph[0])
          P_SRC_EXT, P_DST_EXT: e_ext = 1'b1;
          P_SRC_IDX: begin e_rd = 1'b1; e_addr = 2'd1; end
          P_SRC_IND: begin e_rd = 1'b1; e_addr = 2'd2; end
          P_SRC_INC: begin e_rd = 1'b1; e_addr = 2'd2; e_inc = mem_ack; end
          P_DST_MEM: begin e_rd = 1'b1; e_addr = 2'd3; end
          P_EXEC: begin
            e_alu  = 1'b1;
            e_sr   = sr_of(op);
            e_we   = wb_of(op) && !w[7];
            e_wa   = e_we ? w[3:0] : 4'd0;
            e_done = !(wb_of(op) && w[7]);
          end
          default: begin e_wr = 1'b1; e_addr = 2'd3; e_done = mem_ack; end
        endcase
      end
    end
    chk("ins_ready", ins_ready, e_rdy);   chk("ext_req", ext_req, e_ext);
    chk("mem_rd", mem_rd, e_rd);          chk("mem_wr", mem_wr, e_wr);
    chk("addr_sel", addr_sel, e_addr);    chk("cg_en", cg_en, e_cg);
    chk("src_inc", src_inc, e_inc);       chk("fs", fs, e_fs);
    chk("bw", bw, e_bw);                  chk("alu_en", alu_en, e_alu);
    chk("rf_we", rf_we, e_we);            chk("rf_waddr", rf_waddr, e_wa);
    chk("sr_we", sr_we, e_sr);            chk("fmt_other", fmt_other, e_oth);
    chk("done", done, e_done);
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] w, input logic ea, input logic ma);
    @(posedge clk);
    advance();
    #1;
    rst_n = r; ins_valid = v; ins = w; ext_ack = ea; mem_ack = ma;
    @(negedge clk);
    check_cycle();
  endtask

  initial begin
    int ext_cnt;
    // Reset
    step(0, 0, 16'h0, 0, 0);
    step(0, 1, 16'h4A0B, 0, 0);
    chk("rst_ready", ins_ready, 0);  chk("rst_fs", fs, 4'b0000);
    step(1, 0, 16'h0, 0, 0);
    chk("rel_ready", ins_ready, 1);

    // MOV R10,R11: EXEC right after accept
    step(1, 1, 16'h4A0B, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    chk("mov_alu", alu_en, 1);  chk("mov_fs", fs, 4'b0011);  chk("mov_we", rf_we, 1);
    chk("mov_wa", rf_waddr, 4'hB);  chk("mov_sr", sr_we, 0);  chk("mov_done", done, 1);
    step(1, 0, 16'h0, 0, 0);
    chk("mov_ready", ins_ready, 1);

    // AND #imm,R5 with ext_ack on the third request cycle
    step(1, 1, 16'hF035, 0, 0);
    ext_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'h0, (i == 2), 0);
      ext_cnt += int'(ext_req);
    end
    chk("and_ext_cycles", 4'(ext_cnt), 4'd3);
    step(1, 0, 16'h0, 0, 0);
    chk("and_alu", alu_en, 1);  chk("and_fs", fs, 4'b0000);
    chk("and_sr", sr_we, 1);    chk("and_wa", rf_waddr, 4'd5);

    // CMP R4,X(R6): destination read, no writeback
    step(1, 1, 16'h9486, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    chk("cmp_ext", ext_req, 1);
    step(1, 0, 16'h0, 0, 1);
    chk("cmp_rd", mem_rd, 1);  chk("cmp_addr", addr_sel, 2'd3);
    step(1, 0, 16'h0, 0, 0);
    chk("cmp_fs", fs, 4'b1100);  chk("cmp_sr", sr_we, 1);  chk("cmp_we", rf_we, 0);
    chk("cmp_wr", mem_wr, 0);    chk("cmp_done", done, 1);

    // BIC.B @R7+,R8: indirect read with post-increment on the ack
    step(1, 1, 16'hC778, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    chk("bic_addr", addr_sel, 2'd2);  chk("bic_inc_wait", src_inc, 0);
    step(1, 0, 16'h0, 0, 1);
    chk("bic_inc", src_inc, 1);  chk("bic_bw", bw, 1);
    step(1, 0, 16'h0, 0, 0);
    chk("bic_fs", fs, 4'b1000);  chk("bic_sr", sr_we, 0);  chk("bic_wa", rf_waddr, 4'd8);

    // Non-format-I opcode
    step(1, 1, 16'h1234, 0, 0);
    chk("oth_pulse", fmt_other, 1);  chk("oth_ready", ins_ready, 1);
    step(1, 0, 16'h0, 0, 0);
    chk("oth_clear", fmt_other, 0);  chk("oth_alu", alu_en, 0);  chk("oth_ready2", ins_ready, 1);

    // Reset during memory writeback (MOV R4,X(R6))
    step(1, 1, 16'h4486, 0, 0);
    step(1, 0, 16'h0, 1, 0);
    step(1, 0, 16'h0, 0, 1);
    step(1, 0, 16'h0, 0, 0);
    step(1, 0, 16'h0, 0, 0);
    chk("wb_wr", mem_wr, 1);
    step(0, 1, 16'h4A0B, 0, 1);
    chk("wbrst_wr", mem_wr, 0);  chk("wbrst_ready", ins_ready, 0);
    step(1, 0, 16'h0, 0, 0);
    chk("wbrst_rel", ins_ready, 1);
    step(1, 0, 16'h0, 0, 0);
    chk("wbrst_noacc", alu_en, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++)
      step(($urandom_range(0, 149) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
